// File: rtl/sprite_tex_loader_pkg.sv
// Shared definitions for the sprite texture loader: default texture geometry,
// SDRAM source addresses, FSM/section encodings and the burst-length helper.
package sprite_tex_loader_pkg;

    localparam int unsigned DEF_BIRD_WORDS = 5250;
    localparam int unsigned DEF_PIPE_WORDS = 4000;
    localparam int unsigned DEF_BASE_WORDS = 9600;
    localparam logic [23:0] DEF_BIRD_SRC   = 24'h100000;
    localparam logic [23:0] DEF_PIPE_SRC   = 24'h110000;
    localparam logic [23:0] DEF_BASE_SRC   = 24'h120000;
    localparam int unsigned DEF_BURST_LEN  = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_NEXT_SEC,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        SEC_BIRD,
        SEC_PIPE,
        SEC_BASE
    } sec_t;

    // Words left in the section, capped at the maximum burst size.
    function automatic logic [8:0] burst_len(input logic [13:0] words,
                                             input logic [13:0] idx,
                                             input logic [8:0]  max_len);
        logic [13:0] rem;
        rem = words - idx;
        if (rem > {5'd0, max_len})
            return max_len;
        return rem[8:0];
    endfunction

endpackage

// File: rtl/sprite_tex_loader.sv
// Boot-time sequencer: copies bird, pipe-cap and ground textures from SDRAM
// into the sprite RAMs using length-limited read bursts, then raises tex_ready.
module sprite_tex_loader
    import sprite_tex_loader_pkg::*;
#(
    parameter int unsigned BIRD_WORDS = DEF_BIRD_WORDS,
    parameter int unsigned PIPE_WORDS = DEF_PIPE_WORDS,
    parameter int unsigned BASE_WORDS = DEF_BASE_WORDS,
    parameter logic [23:0] BIRD_SRC   = DEF_BIRD_SRC,
    parameter logic [23:0] PIPE_SRC   = DEF_PIPE_SRC,
    parameter logic [23:0] BASE_SRC   = DEF_BASE_SRC,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        sdram_rd_req,
    output logic [23:0] sdram_rd_addr,
    output logic [8:0]  sdram_rd_len,
    input  logic        sdram_rd_ack,
    input  logic        sdram_rd_valid,
    input  logic [15:0] sdram_rd_data,
    output logic [15:0] load_data,
    output logic        bird_load_en,
    output logic [12:0] bird_load_addr,
    output logic        pipe_load_en,
    output logic [15:0] pipe_load_addr,
    output logic        base_load_en,
    output logic [13:0] base_load_addr,
    output logic        busy,
    output logic        done,
    output logic        tex_ready
);

    state_t      state;
    sec_t        sec;
    logic [13:0] idx;
    logic [13:0] idx_inc;
    logic [8:0]  bcnt;
    logic [8:0]  bcnt_inc;
    logic [23:0] sec_src;
    logic [13:0] sec_words;

    always_comb begin
        sec_src   = BIRD_SRC;
        sec_words = 14'(BIRD_WORDS);
        case (sec)
            SEC_BIRD: begin
                sec_src   = BIRD_SRC;
                sec_words = 14'(BIRD_WORDS);
            end
            SEC_PIPE: begin
                sec_src   = PIPE_SRC;
                sec_words = 14'(PIPE_WORDS);
            end
            SEC_BASE: begin
                sec_src   = BASE_SRC;
                sec_words = 14'(BASE_WORDS);
            end
            default: ;
        endcase
    end

    assign idx_inc  = idx + 14'd1;
    assign bcnt_inc = bcnt + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            sec            <= SEC_BIRD;
            idx            <= '0;
            bcnt           <= '0;
            sdram_rd_req   <= 1'b0;
            sdram_rd_addr  <= '0;
            sdram_rd_len   <= '0;
            load_data      <= '0;
            bird_load_en   <= 1'b0;
            bird_load_addr <= '0;
            pipe_load_en   <= 1'b0;
            pipe_load_addr <= '0;
            base_load_en   <= 1'b0;
            base_load_addr <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tex_ready      <= 1'b0;
        end else begin
            bird_load_en <= 1'b0;
            pipe_load_en <= 1'b0;
            base_load_en <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sec       <= SEC_BIRD;
                        idx       <= '0;
                        tex_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                // First REQ cycle latches the request; it is then held until ack.
                ST_REQ: begin
                    if (!sdram_rd_req) begin
                        sdram_rd_req  <= 1'b1;
                        sdram_rd_addr <= sec_src + 24'(idx);
                        sdram_rd_len  <= burst_len(sec_words, idx, 9'(BURST_LEN));
                    end else if (sdram_rd_ack) begin
                        sdram_rd_req <= 1'b0;
                        bcnt         <= '0;
                        state        <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sdram_rd_valid) begin
                        load_data <= sdram_rd_data;
                        case (sec)
                            SEC_BIRD: begin
                                bird_load_en   <= 1'b1;
                                bird_load_addr <= idx[12:0];
                            end
                            SEC_PIPE: begin
                                pipe_load_en   <= 1'b1;
                                pipe_load_addr <= {2'b00, idx};
                            end
                            default: begin
                                base_load_en   <= 1'b1;
                                base_load_addr <= idx;
                            end
                        endcase
                        idx  <= idx_inc;
                        bcnt <= bcnt_inc;
                        if (bcnt_inc == sdram_rd_len)
                            state <= (idx_inc == sec_words) ? ST_NEXT_SEC : ST_REQ;
                    end
                end
                ST_NEXT_SEC: begin
                    idx <= '0;
                    case (sec)
                        SEC_BIRD: begin
                            sec   <= SEC_PIPE;
                            state <= ST_REQ;
                        end
                        SEC_PIPE: begin
                            sec   <= SEC_BASE;
                            state <= ST_REQ;
                        end
                        default: begin
                            done      <= 1'b1;
                            tex_ready <= 1'b1;
                            state     <= ST_FIN;
                        end
                    endcase
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_tex_loader.sv
// Randomized scoreboard bench for sprite_tex_loader: an SDRAM model feeds bursts
// derived from the texture layout; a negedge monitor checks every RAM write.
module tb_sprite_tex_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sdram_rd_req;
    logic [23:0] sdram_rd_addr;
    logic [8:0]  sdram_rd_len;
    logic        sdram_rd_ack;
    logic        sdram_rd_valid;
    logic [15:0] sdram_rd_data;
    logic [15:0] load_data;
    logic        bird_load_en;
    logic [12:0] bird_load_addr;
    logic        pipe_load_en;
    logic [15:0] pipe_load_addr;
    logic        base_load_en;
    logic [13:0] base_load_addr;
    logic        busy;
    logic        done;
    logic        tex_ready;

    sprite_tex_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sdram_rd_req   (sdram_rd_req),
        .sdram_rd_addr  (sdram_rd_addr),
        .sdram_rd_len   (sdram_rd_len),
        .sdram_rd_ack   (sdram_rd_ack),
        .sdram_rd_valid (sdram_rd_valid),
        .sdram_rd_data  (sdram_rd_data),
        .load_data      (load_data),
        .bird_load_en   (bird_load_en),
        .bird_load_addr (bird_load_addr),
        .pipe_load_en   (pipe_load_en),
        .pipe_load_addr (pipe_load_addr),
        .base_load_en   (base_load_en),
        .base_load_addr (base_load_addr),
        .busy           (busy),
        .done           (done),
        .tex_ready      (tex_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          WORDS [3] = '{5250, 4000, 9600};
    logic [23:0] SRC   [3] = '{24'h100000, 24'h110000, 24'h120000};

    typedef struct {
        int          sec;
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t  sbq[$];
    int   total = 0;
    int   bad = 0;
    int   wr_cnt [3];
    int   done_cnt = 0;
    bit   hung = 0;
    bit   streaming = 0;
    logic exp_en_q = 1'b0;
    logic prev_base_en = 1'b0;
    int   m_n, m_sec, m_addr;
    wr_t  m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A write is expected exactly one cycle after each word the model streams.
    always @(posedge clk) exp_en_q <= streaming && sdram_rd_valid;

    always @(negedge clk) begin
        if (rst_n) begin
            m_n = int'(bird_load_en) + int'(pipe_load_en) + int'(base_load_en);
            chk("onehot_en", 64'(m_n <= 1), 64'd1);
            chk("en_mirrors_valid", 64'(m_n != 0), 64'(exp_en_q));
            if (m_n == 1) begin
                m_sec  = bird_load_en ? 0 : (pipe_load_en ? 1 : 2);
                m_addr = bird_load_en ? int'(bird_load_addr) :
                         (pipe_load_en ? int'(pipe_load_addr) : int'(base_load_addr));
                if (sbq.size() == 0) begin
                    chk("write_expected", 64'd0, 64'd1);
                end else begin
                    m_e = sbq.pop_front();
                    chk("wr_sec", 64'(m_sec), 64'(m_e.sec));
                    chk("wr_addr", 64'(m_addr), 64'(m_e.addr));
                    chk("wr_data", 64'(load_data), 64'(m_e.data));
                    wr_cnt[m_sec]++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_tex_ready", 64'(tex_ready), 64'd1);
                chk("done_after_last_base", 64'(prev_base_en), 64'd1);
                chk("done_queue_empty", 64'(sbq.size()), 64'd0);
            end
            prev_base_en = base_load_en;
        end else begin
            prev_base_en = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_grp"}, 64'({sdram_rd_req, sdram_rd_addr, sdram_rd_len, load_data}), 64'd0);
        chk({tag, "_ram_grp"}, 64'({bird_load_en, bird_load_addr, pipe_load_en, pipe_load_addr,
                                    base_load_en, base_load_addr, busy, done, tex_ready}), 64'd0);
    endtask

    task automatic do_burst(input int s, input int idx0, input int len, input int ack_dly,
                            input int gap_pct, input int abort_idx, input bit pulse_mid,
                            output bit aborted);
        logic [23:0] ea;
        logic [8:0]  el;
        int          waited;
        int          k;
        bit          pulsed;
        aborted = 0;
        pulsed  = 0;
        ea      = SRC[s] + 24'(idx0);
        el      = 9'(len);
        waited  = 0;
        while (!sdram_rd_req && waited < 200) begin
            step();
            waited++;
        end
        if (!sdram_rd_req) begin
            chk("req_timeout", 64'd0, 64'd1);
            hung = 1;
            return;
        end
        chk("req_addr", 64'(sdram_rd_addr), 64'(ea));
        chk("req_len", 64'(sdram_rd_len), 64'(el));
        for (int d = 0; d < ack_dly; d++) begin
            step();
            chk("req_hold", 64'({sdram_rd_req, sdram_rd_addr, sdram_rd_len}), 64'({1'b1, ea, el}));
        end
        sdram_rd_ack = 1'b1;
        step();
        sdram_rd_ack = 1'b0;
        chk("req_drop_after_ack", 64'(sdram_rd_req), 64'd0);
        streaming = 1;
        k = 0;
        while (k < len) begin
            if (abort_idx >= 0 && idx0 + k == abort_idx) begin
                aborted = 1;
                break;
            end
            if (pulse_mid && !pulsed && k >= 5) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            sdram_rd_data = 16'($urandom);
            if ($urandom_range(99) < gap_pct) begin
                sdram_rd_valid = 1'b0;
            end else begin
                sdram_rd_valid = 1'b1;
                sbq.push_back('{s, idx0 + k, sdram_rd_data});
                k++;
            end
            step();
        end
        sdram_rd_valid = 1'b0;
        start          = 1'b0;
        streaming      = 0;
    endtask

    // Reference walk of the load order: sections in order, bursts of at most 256 words.
    task automatic run_seq(input int ack_dly, input int gap_pct, input int abort_sec,
                           input int abort_idx, input bit pulse_pipe, output bit aborted);
        int idx;
        int len;
        bit ab;
        aborted = 0;
        for (int s = 0; s < 3; s++) begin
            idx = 0;
            while (idx < WORDS[s] && !hung) begin
                len = (WORDS[s] - idx > 256) ? 256 : WORDS[s] - idx;
                do_burst(s, idx, len, ack_dly, gap_pct, (s == abort_sec) ? abort_idx : -1,
                         pulse_pipe && s == 1 && idx == 0, ab);
                if (ab) begin
                    aborted = 1;
                    return;
                end
                idx += len;
            end
        end
    endtask

    task automatic wait_done(input int exp_done);
        int c;
        c = 0;
        while (done_cnt < exp_done && c < 50) begin
            step();
            c++;
        end
        repeat (3) step();
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("tex_ready_sticky", 64'(tex_ready), 64'd1);
        for (int s = 0; s < 3; s++)
            chk("section_write_count", 64'(wr_cnt[s]), 64'(WORDS[s]));
    endtask

    task automatic idle_noise();
        for (int i = 0; i < 8; i++) begin
            sdram_rd_valid = 1'(i % 2);
            sdram_rd_ack   = 1'(i % 3 == 0);
            sdram_rd_data  = 16'($urandom);
            step();
        end
        sdram_rd_valid = 1'b0;
        sdram_rd_ack   = 1'b0;
        step();
        chk("idle_noise_req", 64'(sdram_rd_req), 64'd0);
        chk("idle_noise_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        bit ab;
        rst_n          = 1'b1;
        start          = 1'b0;
        sdram_rd_ack   = 1'b0;
        sdram_rd_valid = 1'b0;
        sdram_rd_data  = '0;
        for (int s = 0; s < 3; s++) wr_cnt[s] = 0;
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        idle_noise();

        // Zero-wait full load.
        pulse_start();
        chk("busy_on_start", 64'(busy), 64'd1);
        run_seq(0, 0, -1, -1, 0, ab);
        wait_done(1);
        idle_noise();

        // Delayed ack, gappy data, stray start during the pipe section.
        for (int s = 0; s < 3; s++) wr_cnt[s] = 0;
        pulse_start();
        chk("tex_ready_cleared", 64'(tex_ready), 64'd0);
        if (!hung) run_seq(5, 30, -1, -1, 1, ab);
        wait_done(2);

        // Reset while pipe word 1000 is pending, then a fresh start.
        for (int s = 0; s < 3; s++) wr_cnt[s] = 0;
        pulse_start();
        if (!hung) run_seq(0, 10, 1, 1000, 0, ab);
        chk("abort_reached", 64'(ab), 64'd1);
        @(negedge clk);
        #1;
        chk("pipe_words_before_reset", 64'(wr_cnt[1]), 64'd1000);
        chk("queue_drained_before_reset", 64'(sbq.size()), 64'd0);
        rst_n = 1'b0;
        #1 check_outputs_zero("midrun_reset");
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        for (int s = 0; s < 3; s++) wr_cnt[s] = 0;
        pulse_start();
        if (!hung) run_seq(0, 0, 0, 8, 0, ab);
        step();
        step();
        chk("restart_bird_writes", 64'(wr_cnt[0]), 64'd8);
        chk("restart_queue_drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
